// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the accumulator write-back controller.
package mem_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DRAIN
  } wr_state_e;

endpackage

// File: rtl/wr_skew_pipe.sv
// Diagonal write-enable skew with one address counter per memory bank.
module wr_skew_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned SYS_COL    = 16,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  valid_in,
  output logic [SYS_COL-1:0]    wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr [SYS_COL]
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_out <= '0;
      for (int unsigned j = 0; j < SYS_COL; j++) begin
        wr_addr[j] <= '1;
      end
    end else begin
      wr_en_out <= {wr_en_out[SYS_COL-2:0], valid_in};
      // Clear wins over the final bank's post-write increment at job end.
      for (int unsigned j = 0; j < SYS_COL; j++) begin
        if (clear) begin
          wr_addr[j] <= '1;
        end else if (load) begin
          wr_addr[j] <= base_addr;
        end else if (wr_en_out[j]) begin
          wr_addr[j] <= wr_addr[j] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_wr_ctrl.sv
// Write-back controller: accepts result rows and skews bank writes across columns.
module mem_wr_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned SYS_COL    = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACCUM_SIZE = 4096,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_start,
  input  logic [DATA_WIDTH-1:0] num_row,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic [SYS_COL-1:0]    wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr [SYS_COL],
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned ACCUM_ROW = ACCUM_SIZE / SYS_COL;
  localparam int unsigned CNT_W     = $clog2(ACCUM_ROW) + 1;
  localparam int unsigned DRN_W     = $clog2(SYS_COL) + 1;

  localparam logic [CNT_W-1:0]      ACCUM_ROW_C = CNT_W'(ACCUM_ROW);
  localparam logic [DATA_WIDTH-1:0] ACCUM_ROW_D = DATA_WIDTH'(ACCUM_ROW);
  localparam logic [DRN_W-1:0]      DRAIN_LAST  = DRN_W'(SYS_COL - 1);

  wr_state_e        state;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] row_cnt;
  logic [DRN_W-1:0] drain_cnt;

  logic [CNT_W-1:0] row_cnt_inc;
  logic [CNT_W-1:0] limit_nxt;
  logic             accept;
  logic             load;
  logic             clear;
  logic             drain_end;

  always_comb begin
    row_cnt_inc = row_cnt + 1'b1;
    limit_nxt   = (num_row > ACCUM_ROW_D) ? ACCUM_ROW_C : num_row[CNT_W-1:0];
    accept      = (state == ST_WRITE) && in_valid;
    load        = (state == ST_IDLE) && wr_start && (num_row != '0);
    drain_end   = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
    clear       = drain_end;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      limit     <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) err <= 1'b1;
          if (wr_start) begin
            if (num_row != '0) begin
              limit   <= limit_nxt;
              row_cnt <= '0;
              state   <= ST_WRITE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (accept) begin
            row_cnt <= row_cnt_inc;
            if (row_cnt_inc == limit) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (in_valid) err <= 1'b1;
          // Drain covers the skew so the last column's write lands before done.
          if (drain_end) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wr_skew_pipe #(
    .SYS_COL    (SYS_COL),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skew (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .clear     (clear),
    .base_addr (base_addr),
    .valid_in  (accept),
    .wr_en_out (wr_en_out),
    .wr_addr   (wr_addr)
  );

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Scoreboard bench for mem_wr_ctrl: expected bank writes, done and err pulses are queued per cycle.
module tb_mem_wr_ctrl;

  localparam int NCOL = 16;
  localparam int AROW = 256;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_start;
  logic [15:0] num_row;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic [NCOL-1:0] wr_en_out;
  logic [7:0]  wr_addr [NCOL];
  logic        busy;
  logic        done;
  logic        err;

  mem_wr_ctrl #(
    .SYS_COL    (16),
    .DATA_WIDTH (16),
    .ACCUM_SIZE (4096),
    .ADDR_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_start  (wr_start),
    .num_row   (num_row),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .wr_en_out (wr_en_out),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] addr;
  } wr_exp_t;

  wr_exp_t exp_wr [NCOL][$];
  int      done_q [$];
  int      err_q  [$];

  // Reference model of the controller's acceptance behaviour.
  logic       m_job_open = 1'b0;
  int         m_idle_at  = 0;
  int         m_start    = 0;
  int         m_cnt      = 0;
  int         m_limit    = 0;
  logic [7:0] m_base     = '0;

  task automatic tick(input logic s, input logic [15:0] n, input logic [7:0] b, input logic v);
    int c;
    wr_exp_t e;
    c = cyc;
    wr_start  = s;
    num_row   = n;
    base_addr = b;
    in_valid  = v;
    if (v) begin
      if (m_job_open && c > m_start) begin
        for (int j = 0; j < NCOL; j++) begin
          e.cyc  = c + 1 + j;
          e.addr = m_base + 8'(m_cnt);
          exp_wr[j].push_back(e);
        end
        m_cnt++;
        if (m_cnt == m_limit) begin
          m_job_open = 1'b0;
          m_idle_at  = c + NCOL + 1;
          done_q.push_back(m_idle_at);
        end
      end else begin
        err_q.push_back(c + 1);
      end
    end
    if (s && !m_job_open && c >= m_idle_at) begin
      if (n != 16'd0) begin
        m_job_open = 1'b1;
        m_start    = c;
        m_base     = b;
        m_cnt      = 0;
        m_limit    = (int'(n) > AROW) ? AROW : int'(n);
      end else begin
        done_q.push_back(c + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'd0, 8'd0, 1'b0);
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en_out), 32'd0);
    for (int j = 0; j < NCOL; j++) check($sformatf("%s_addr%0d", tag, j), 32'(wr_addr[j]), 32'hFF);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  logic mon_exp;
  always @(negedge clk) begin
    if (rstn) begin
      for (int j = 0; j < NCOL; j++) begin
        mon_exp = (exp_wr[j].size() != 0) && (exp_wr[j][0].cyc == cyc);
        check($sformatf("wr_en[%0d]", j), 32'(wr_en_out[j]), 32'(mon_exp));
        if (mon_exp) begin
          check($sformatf("wr_addr[%0d]", j), 32'(wr_addr[j]), 32'(exp_wr[j][0].addr));
          void'(exp_wr[j].pop_front());
        end
      end
      mon_exp = (done_q.size() != 0) && (done_q[0] == cyc);
      check("done", 32'(done), 32'(mon_exp));
      if (mon_exp) void'(done_q.pop_front());
      mon_exp = (err_q.size() != 0) && (err_q[0] == cyc);
      check("err", 32'(err), 32'(mon_exp));
      if (mon_exp) void'(err_q.pop_front());
    end
  end

  initial begin
    rstn = 1'b0;
    wr_start = 1'b0; num_row = '0; base_addr = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_reset("rst");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Stray in_valid while idle
    tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(3);

    // Three contiguous rows from 0x10
    tick(1'b1, 16'd3, 8'h10, 1'b0);
    check("busy_start", 32'(busy), 32'd1);
    repeat (3) tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(NCOL + 4);
    check("busy_idle1", 32'(busy), 32'd0);
    for (int j = 0; j < NCOL; j++) check($sformatf("addr_ff1_%0d", j), 32'(wr_addr[j]), 32'hFF);

    // Address wrap
    tick(1'b1, 16'd4, 8'hFE, 1'b0);
    repeat (4) tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(NCOL + 4);

    // Gap in in_valid
    tick(1'b1, 16'd2, 8'h33, 1'b0);
    tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(2);
    tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(NCOL + 4);

    // Oversized job clamps to ACCUM_ROW; extra rows error out
    tick(1'b1, 16'd300, 8'h00, 1'b0);
    repeat (300) tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(NCOL + 4);
    check("busy_idle2", 32'(busy), 32'd0);
    for (int j = 0; j < NCOL; j++) check($sformatf("addr_ff2_%0d", j), 32'(wr_addr[j]), 32'hFF);

    // Zero-row job
    tick(1'b1, 16'd0, 8'h77, 1'b0);
    idle(4);
    check("addr_ff_zero", 32'(wr_addr[0]), 32'hFF);

    // wr_start while busy in WRITE and in DRAIN is ignored
    tick(1'b1, 16'd3, 8'h40, 1'b0);
    tick(1'b0, 16'd0, 8'd0, 1'b1);
    tick(1'b1, 16'd5, 8'h80, 1'b1);
    tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(3);
    tick(1'b1, 16'd5, 8'h80, 1'b0);
    idle(NCOL + 4);
    check("busy_idle3", 32'(busy), 32'd0);

    // Reset mid-job after 5 of 8 rows
    tick(1'b1, 16'd8, 8'h20, 1'b0);
    repeat (5) tick(1'b0, 16'd0, 8'd0, 1'b1);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_outputs_reset("midrst");
    for (int j = 0; j < NCOL; j++) exp_wr[j].delete();
    done_q.delete();
    err_q.delete();
    m_job_open = 1'b0;
    m_idle_at  = 0;
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    idle(NCOL + 4);
    tick(1'b1, 16'd2, 8'h50, 1'b0);
    repeat (2) tick(1'b0, 16'd0, 8'd0, 1'b1);
    idle(NCOL + 4);
    check("busy_idle4", 32'(busy), 32'd0);

    for (int j = 0; j < NCOL; j++) check($sformatf("wr_q_left%0d", j), 32'(exp_wr[j].size()), 32'd0);
    check("done_q_left", 32'(done_q.size()), 32'd0);
    check("err_q_left", 32'(err_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
